// File: rtl/canon_voice_scheduler.sv
// Beat/entry sequencer for a 4-voice canon: shares one note-ROM port and rotates divider slots.
// Latency: ROM request one cycle after a voice wants a note; slot_note is one cycle behind the note latch.
// Backpressure: one outstanding ROM request, held stable until rom_ack, then at least one idle cycle.
module canon_voice_scheduler #(
    parameter int VOICES = 4,
    parameter int IDX_W  = 9,
    parameter int BEAT_W = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [BEAT_W-1:0]         beat_len,
    input  logic [7:0]                entry_beats,
    input  logic [IDX_W-1:0]          loop_start,
    input  logic [IDX_W-1:0]          loop_end,
    output logic                      rom_req,
    output logic [$clog2(VOICES)-1:0] rom_voice,
    output logic [IDX_W-1:0]          rom_idx,
    input  logic                      rom_ack,
    input  logic [6:0]                rom_note,
    output logic [$clog2(VOICES)-1:0] slot,
    output logic [6:0]                slot_note,
    output logic                      beat_tick,
    output logic [VOICES-1:0]         voice_active
);
    localparam int VW = $clog2(VOICES);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PLAY = 2'd2} voice_state_t;

    logic [BEAT_W-1:0] beat_cnt;
    logic [7:0]        elapsed;
    logic              tick;
    logic              ack_ok;
    logic              init_pend;
    voice_state_t      state    [VOICES];
    voice_state_t      state_nx [VOICES];
    logic [IDX_W-1:0]  idx      [VOICES];
    logic [6:0]        note     [VOICES];
    logic [3:0]        remain   [VOICES];
    logic [VOICES-1:0] ack_hit;
    logic              pick_vld;
    logic [VW-1:0]     pick_v;
    logic [VW-1:0]     cand;
    logic [VW-1:0]     rr_ptr;
    logic [VW-1:0]     slot_nx;

    // Duration code to beat count; code 3 is deliberately shorter than code 2.
    function automatic logic [3:0] dur_beats(input logic [1:0] code);
        case (code)
            2'd0:    dur_beats = 4'd1;
            2'd1:    dur_beats = 4'd2;
            2'd2:    dur_beats = 4'd8;
            default: dur_beats = 4'd4;
        endcase
    endfunction

    // Restart suppresses the tick so a fresh run never counts a beat from the aborted one.
    assign tick      = enable & ~restart & (beat_cnt == beat_len);
    assign beat_tick = tick & ~rst;
    assign ack_ok    = rom_req & rom_ack & ~restart;
    assign slot_nx   = slot + VW'(1);

    // Beat period counter and saturating elapsed-beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            elapsed  <= 8'd0;
        end else if (restart) begin
            beat_cnt <= '0;
            elapsed  <= 8'd0;
        end else if (enable) begin
            beat_cnt <= tick ? '0 : beat_cnt + BEAT_W'(1);
            if (tick && elapsed != 8'hFF) begin
                elapsed <= elapsed + 8'd1;
            end
        end
    end

    // Per-voice next state: staggered entry, note fetch, note playback.
    always_comb begin
        ack_hit = '0;
        for (int v = 0; v < VOICES; v++) begin
            state_nx[v] = state[v];
            if (restart) begin
                state_nx[v] = IDLE;
            end else begin
                case (state[v])
                    IDLE: begin
                        if (enable && ({8'd0, elapsed} >= 16'(16'(v) * {8'd0, entry_beats}))) begin
                            state_nx[v] = FETCH;
                        end
                    end
                    FETCH: begin
                        if (ack_ok && rom_voice == VW'(v)) begin
                            ack_hit[v]  = 1'b1;
                            state_nx[v] = PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick && remain[v] == 4'd1) begin
                            state_nx[v] = FETCH;
                        end
                    end
                    default: state_nx[v] = IDLE;
                endcase
            end
        end
    end

    // Voice state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                state[v] <= IDLE;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                state[v] <= state_nx[v];
            end
        end
    end

    // Per-voice note, remaining beats and ROM index; indices pick up loop_start right after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_pend <= 1'b1;
            for (int v = 0; v < VOICES; v++) begin
                idx[v]    <= '0;
                note[v]   <= 7'd0;
                remain[v] <= 4'd0;
            end
        end else begin
            init_pend <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                if (restart) begin
                    idx[v]    <= loop_start;
                    note[v]   <= 7'd0;
                    remain[v] <= 4'd0;
                end else if (init_pend) begin
                    idx[v] <= loop_start;
                end else if (ack_hit[v]) begin
                    note[v]   <= rom_note;
                    remain[v] <= dur_beats(rom_note[6:5]);
                    idx[v]    <= (idx[v] == loop_end) ? loop_start : idx[v] + IDX_W'(1);
                end else if (state[v] == PLAY && tick) begin
                    remain[v] <= remain[v] - 4'd1;
                end
            end
        end
    end

    // Round-robin search for the first fetching voice at or after the pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_v   = '0;
        cand     = '0;
        for (int k = 0; k < VOICES; k++) begin
            cand = rr_ptr + VW'(k);
            if (!pick_vld && state[cand] == FETCH) begin
                pick_vld = 1'b1;
                pick_v   = cand;
            end
        end
    end

    // ROM request register: issue from idle, hold until ack, drop on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_req   <= 1'b0;
            rom_voice <= '0;
            rom_idx   <= '0;
            rr_ptr    <= '0;
        end else if (restart) begin
            rom_req <= 1'b0;
        end else if (rom_req) begin
            if (rom_ack) begin
                rom_req <= 1'b0;
                rr_ptr  <= rom_voice + VW'(1);
            end
        end else if (pick_vld) begin
            rom_req   <= 1'b1;
            rom_voice <= pick_v;
            rom_idx   <= idx[pick_v];
        end
    end

    // Free-running slot rotation with the matching voice's note, masked while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            slot_note <= 7'd0;
        end else begin
            slot      <= slot_nx;
            slot_note <= (state[slot_nx] != IDLE) ? note[slot_nx] : 7'd0;
        end
    end

    // Activity flags straight from the voice states.
    always_comb begin
        voice_active = '0;
        for (int v = 0; v < VOICES; v++) begin
            voice_active[v] = (state[v] != IDLE);
        end
    end

endmodule

// File: doc/canon_voice_scheduler.md
Name: canon_voice_scheduler

Overview:
- Sequences the shared note ROM and the time-multiplexed divider slots for a 4-voice canon.
- Generates the beat tick and staggers voice entries so that each voice starts the same melody entry_beats after the previous one.
- Fetches each voice's next note through a single round-robin-arbitrated ROM port and tracks note durations per voice.
- Presents one voice's current note per clock, in rotating slot order, to the downstream frequency/divider stage.

Parameters:
VOICES, 4, number of voices/slots (power of two)
IDX_W, 9, note ROM index width
BEAT_W, 22, beat period counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  run; low freezes beat counter, elapsed-beat count and durations
restart  in  1  synchronous pulse; returns all voices to IDLE
beat_len  in  BEAT_W  beat period minus 1, in clocks
entry_beats  in  8  beats between successive voice entries
loop_start  in  IDX_W  first ROM index of melody
loop_end  in  IDX_W  last ROM index of melody
rom_req  out  1  ROM request
rom_voice  out  log2(VOICES)  requesting voice
rom_idx  out  IDX_W  ROM index requested
rom_ack  in  1  ROM data valid, consumes request
rom_note  in  7  note code: [6:5] duration code, [4:0] pitch (0 = rest)
slot  out  log2(VOICES)  voice presented this cycle
slot_note  out  7  note of voice `slot`; 0 if voice IDLE
beat_tick  out  1  one-cycle pulse per beat
voice_active  out  VOICES  bit v = voice v not IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; beat counter 0; elapsed beats E=0; all voices IDLE; voice indices = loop_start sampled at reset release; RR pointer 0.
- Beat counter:
  - When enable=1, counts 0..beat_len.
  - At beat_len: wraps to 0 and beat_tick=1 for that cycle.
  - beat_len=0 gives a tick every enabled cycle.
  - E increments on each tick and saturates at 255.
- Per-voice FSM (IDLE, FETCH, PLAY):
  - IDLE->FETCH when enable=1 and E >= v*entry_beats. Voice 0 leaves IDLE on the first enabled cycle. Product is computed at 16 bits.
  - FETCH: voice is a request candidate. On rom_ack for this voice:
    - latch rom_note and load remaining beats from the duration code: 0->1, 1->2, 2->8, 3->4;
    - advance the index: idx==loop_end ? loop_start : idx+1, mod 2^IDX_W;
    - go to PLAY.
  - PLAY: each beat_tick decrements remaining. A tick with remaining==1 goes to FETCH; the old note stays on slot_note until the new ack (legato).
  - An ack and a tick in the same cycle for the same voice: the ack wins and the tick is not counted against the new note.
- Arbiter:
  - When rom_req=0 and any voice is in FETCH, pick the first FETCH voice at or after the RR pointer.
  - The next cycle: rom_req=1, rom_voice/rom_idx registered.
  - rom_req, rom_voice and rom_idx are held stable until rom_ack.
  - On the ack cycle rom_req drops; the pointer moves to granted voice+1.
  - Minimum one idle cycle between requests. Only one request is outstanding at a time.
  - rom_ack while rom_req=0 is ignored.
- Slot rotation:
  - slot increments every clock, mod VOICES, independent of enable.
  - slot_note is registered with slot: it equals the latched note of voice `slot`, or 0 if that voice is IDLE.
  - An ack updates the voice's note one cycle before it can appear in slot_note.
- enable=0:
  - beat counter, E and remaining are frozen; no IDLE exits.
  - An outstanding request completes normally.
- restart=1 (priority over all except rst):
  - next cycle: all voices IDLE, indices=loop_start, E=0, beat counter 0, rom_req=0;
  - an ack in the restart cycle is discarded;
  - slot keeps rotating.
- Index wrap: if loop_start > loop_end, the index still increments mod 2^IDX_W until it hits loop_end.

Test Plan:
- Reset/entry: rst pulse mid-request, then beat_len=3, entry_beats=2, loop 8..11, ROM acks after 2 cycles with note 0x0C (1 beat) -> all outputs 0 during rst; voice_active goes 0001, then 0011 after 2 ticks (cycle 8), 0111 at tick 4, 1111 at tick 6; beat_tick every 4 clocks.
- Durations: ROM returns codes 0,1,2,3 in duration field -> each voice re-requests after 1, 2, 8, 4 ticks respectively; simultaneous ack+tick does not shorten the note.
- Arbitration: all 4 voices in FETCH at once, ack 1 cycle after req -> grants 0,1,2,3 in order; rom_req low one cycle between grants; rom_idx/rom_voice stable while ack withheld 10 cycles.
- Wrap: loop 8..10 -> voice 0 requests indices 8,9,10,8,9; loop_start=510, loop_end=1 -> 510,511,0,1,510.
- Slot output: voices 0,2 active with notes 0x4C, 0x0A -> slot_note sequence 0x4C,0,0x0A,0 repeating, aligned to slot 0..3.
- Freeze/restart: enable low for 20 cycles -> no beat_tick, notes held, pending ack still accepted; restart with an ack in the same cycle -> ack ignored, voice_active=0, next request index = loop_start.
